// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Multiplies retire MUL_STEP bits per cycle; divides are restoring, one bit per cycle, plus a sign fixup.
module muldiv_hilo #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int W2    = 2 * WIDTH;
  localparam int L_MUL = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(L_MUL - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [W2-1:0]      mcand_r, acc_r;
  logic [WIDTH-1:0]   mplier_r, rem_r, quo_r, dvsr_r, hi_r, lo_r;
  logic [1:0]         acc_mode_r;
  logic               neg_p_r, neg_q_r, neg_rem_r, busy_r, done_r, divzero_r;

  logic               op_mul_s, op_div_s, op_mthi_s, op_mtlo_s, op_signed_s;
  logic [1:0]         op_acc_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, rem_next_s;
  logic [W2-1:0]      acc_next_s, prod_s, mul_res_s;
  logic [WIDTH:0]     rem_sh_s, diff_s;
  logic               q_bit_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // Op decode, multiplier step and divider step
  always_comb begin
    op_mul_s    = 1'b0;
    op_div_s    = 1'b0;
    op_mthi_s   = 1'b0;
    op_mtlo_s   = 1'b0;
    op_signed_s = 1'b0;
    op_acc_s    = 2'd0;
    case (Op)
      4'd0:    begin op_mul_s = 1'b1; op_signed_s = 1'b1; end
      4'd1:    op_mul_s = 1'b1;
      4'd2:    begin op_div_s = 1'b1; op_signed_s = 1'b1; end
      4'd3:    op_div_s = 1'b1;
      4'd4:    begin op_mul_s = 1'b1; op_signed_s = 1'b1; op_acc_s = 2'd1; end
      4'd5:    begin op_mul_s = 1'b1; op_acc_s = 2'd1; end
      4'd6:    begin op_mul_s = 1'b1; op_signed_s = 1'b1; op_acc_s = 2'd2; end
      4'd7:    begin op_mul_s = 1'b1; op_acc_s = 2'd2; end
      4'd8:    op_mthi_s = 1'b1;
      4'd9:    op_mtlo_s = 1'b1;
      default: op_mul_s = 1'b0;
    endcase
    a_mag_s = mag(A, op_signed_s);
    b_mag_s = mag(B, op_signed_s);

    acc_next_s = acc_r + mcand_r * {{(W2-MUL_STEP){1'b0}}, mplier_r[MUL_STEP-1:0]};
    prod_s     = neg_p_r ? -acc_next_s : acc_next_s;
    case (acc_mode_r)
      2'd1:    mul_res_s = {hi_r, lo_r} + prod_s;
      2'd2:    mul_res_s = {hi_r, lo_r} - prod_s;
      default: mul_res_s = prod_s;
    endcase

    rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, dvsr_r};
    if (rem_sh_s >= {1'b0, dvsr_r}) begin
      rem_next_s = diff_s[WIDTH-1:0];
      q_bit_s    = 1'b1;
    end else begin
      rem_next_s = rem_sh_s[WIDTH-1:0];
      q_bit_s    = 1'b0;
    end
  end

  // Control FSM, datapath registers and architectural HI/LO
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CW{1'b0}};
      mcand_r    <= {W2{1'b0}};
      acc_r      <= {W2{1'b0}};
      mplier_r   <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      dvsr_r     <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      acc_mode_r <= 2'd0;
      neg_p_r    <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      divzero_r  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      if (Flush) begin
        state_r <= S_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (Start && op_mul_s) begin
              state_r    <= S_MUL;
              busy_r     <= 1'b1;
              cnt_r      <= {CW{1'b0}};
              acc_r      <= {W2{1'b0}};
              mcand_r    <= {{WIDTH{1'b0}}, a_mag_s};
              mplier_r   <= b_mag_s;
              neg_p_r    <= op_signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
              acc_mode_r <= op_acc_s;
            end else if (Start && op_div_s && (B == {WIDTH{1'b0}})) begin
              done_r    <= 1'b1;
              divzero_r <= 1'b1;
            end else if (Start && op_div_s) begin
              state_r   <= S_DIV;
              busy_r    <= 1'b1;
              cnt_r     <= {CW{1'b0}};
              rem_r     <= {WIDTH{1'b0}};
              quo_r     <= a_mag_s;
              dvsr_r    <= b_mag_s;
              neg_q_r   <= op_signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_r <= op_signed_s & A[WIDTH-1];
            end else if (Start && op_mthi_s) begin
              hi_r   <= A;
              done_r <= 1'b1;
            end else if (Start && op_mtlo_s) begin
              lo_r   <= A;
              done_r <= 1'b1;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_MUL: begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << MUL_STEP;
            mplier_r <= mplier_r >> MUL_STEP;
            cnt_r    <= cnt_r + CNT_ONE;
            if (cnt_r == MUL_LAST) begin
              {hi_r, lo_r} <= mul_res_s;
              state_r      <= S_IDLE;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
            end else begin
              state_r <= S_MUL;
            end
          end
          S_DIV: begin
            rem_r <= rem_next_s;
            quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == DIV_LAST) begin
              state_r <= S_FIX;
            end else begin
              state_r <= S_DIV;
            end
          end
          S_FIX: begin
            hi_r    <= neg_rem_r ? -rem_r : rem_r;
            lo_r    <= neg_q_r ? -quo_r : quo_r;
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign DivZero = divzero_r;
  assign Hi      = hi_r;
  assign Lo      = lo_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_muldiv_hilo;

  logic        Clock, Reset, Start, Flush;
  logic [3:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_hilo #(.WIDTH(32), .MUL_STEP(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el,
                           output int lat, output logic dz, output logic dn);
    logic [63:0] p, hl;
    longint sa, sb;
    hl = {m_hi, m_lo};
    eh = m_hi; el = m_lo; lat = 0; dz = 1'b0; dn = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0 || op == 4'd4 || op == 4'd6) p = 64'(sa * sb);
    else p = {32'h0, a} * {32'h0, b};
    case (op)
      4'd0, 4'd1: begin {eh, el} = p; lat = 8; end
      4'd4, 4'd5: begin {eh, el} = hl + p; lat = 8; end
      4'd6, 4'd7: begin {eh, el} = hl - p; lat = 8; end
      4'd2: if (b == 32'h0) dz = 1'b1;
            else begin el = 32'(sa / sb); eh = 32'(sa % sb); lat = 33; end
      4'd3: if (b == 32'h0) dz = 1'b1;
            else begin el = a / b; eh = a % b; lat = 33; end
      4'd8: eh = a;
      4'd9: el = a;
      default: dn = 1'b0;
    endcase
  endtask

  // Issue one op at the current cycle, scribble on inputs while busy, check the outcome.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int lat, busy_n;
    logic dz, dn, seen;
    ref_model(op, a, b, eh, el, lat, dz, dn);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clock); #1;
    Start = 1'b0;
    busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done) begin seen = 1'b1; break; end
      if (!dn && i >= 3) break;
      if (Busy) busy_n++;
      Start = Busy ? 1'($urandom) : 1'b0;
      Op = 4'($urandom); A = $urandom; B = $urandom;
      @(posedge Clock); #1;
    end
    Start = 1'b0;
    check_eq({tag, "_done"}, 64'(seen), 64'(dn));
    check_eq({tag, "_busycycles"}, 64'(busy_n), 64'(lat));
    check_eq({tag, "_divzero"}, 64'(DivZero), 64'(dz));
    check_eq({tag, "_hi"}, 64'(Hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(Lo), 64'(el));
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    logic [31:0] x;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        any_done;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 4'd0; A = 32'h0; B = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    check_eq("rst_hi", 64'(Hi), 64'h0);
    check_eq("rst_lo", 64'(Lo), 64'h0);
    check_eq("rst_busy", 64'(Busy), 64'h0);
    check_eq("rst_done", 64'(Done), 64'h0);
    check_eq("rst_divzero", 64'(DivZero), 64'h0);

    run_op(4'd8, 32'h12345678, 32'h0, "mthi");
    run_op(4'd9, 32'h9ABCDEF0, 32'h0, "mtlo");
    check_eq("mt_const", {Hi, Lo}, 64'h12345678_9ABCDEF0);
    run_op(4'd0, 32'hFFFFFFFF, 32'h2, "mult");
    check_eq("mult_const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(4'd1, 32'hFFFFFFFF, 32'h2, "multu");
    check_eq("multu_const", {Hi, Lo}, 64'h00000001_FFFFFFFE);
    run_op(4'd2, 32'hFFFFFFF9, 32'h2, "div");
    check_eq("div_const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd3, 32'h7, 32'h0, "divu_zero");
    run_op(4'd8, 32'h0, 32'h0, "mthi0");
    run_op(4'd9, 32'hFFFFFFFF, 32'h0, "mtlo_ones");
    run_op(4'd5, 32'h1, 32'h1, "maddu");
    check_eq("maddu_const", {Hi, Lo}, 64'h00000001_00000000);
    run_op(4'd7, 32'h1, 32'h1, "msubu");
    check_eq("msubu_const", {Hi, Lo}, 64'h00000000_FFFFFFFF);
    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, "div_minint");
    check_eq("minint_const", {Hi, Lo}, 64'h00000000_80000000);
    run_op(4'd12, 32'h5, 32'h6, "invalid");

    // MULT aborted by Flush; a Start issued mid-flight must be ignored
    Start = 1'b1; Op = 4'd0; A = $urandom; B = $urandom;
    @(posedge Clock); #1; Start = 1'b0;
    @(posedge Clock); #1; Start = 1'b1; Op = 4'd9; A = $urandom;
    @(posedge Clock); #1; Start = 1'b0;
    @(posedge Clock); #1; Flush = 1'b1;
    @(posedge Clock); #1; Flush = 1'b0;
    check_eq("flush_busy", 64'(Busy), 64'h0);
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any_done |= Done;
      @(posedge Clock); #1;
    end
    check_eq("flush_nodone", 64'(any_done), 64'h0);
    check_eq("flush_hilo", {Hi, Lo}, {m_hi, m_lo});

    // Flush and Start together: Start dropped
    Start = 1'b1; Flush = 1'b1; Op = 4'd8; A = ~m_hi;
    @(posedge Clock); #1; Start = 1'b0; Flush = 1'b0;
    check_eq("flushstart_done", 64'(Done), 64'h0);
    check_eq("flushstart_hi", 64'(Hi), 64'(m_hi));

    // Flush in the Done cycle does not undo the commit
    x = $urandom;
    Start = 1'b1; Op = 4'd8; A = x;
    @(posedge Clock); #1; Start = 1'b0;
    check_eq("donecyc_done", 64'(Done), 64'h1);
    Flush = 1'b1;
    @(posedge Clock); #1; Flush = 1'b0;
    check_eq("donecyc_hi", 64'(Hi), 64'(x));
    m_hi = x;

    // Reset in the middle of a DIV
    Start = 1'b1; Op = 4'd2; A = $urandom; B = $urandom | 32'h1;
    @(posedge Clock); #1; Start = 1'b0;
    repeat (9) begin @(posedge Clock); #1; end
    Reset = 1'b1;
    @(posedge Clock); #1; Reset = 1'b0;
    check_eq("midrst_hilo", {Hi, Lo}, 64'h0);
    check_eq("midrst_flags", {61'h0, Busy, Done, DivZero}, 64'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    run_op(4'd3, 32'd100, 32'd7, "divu_after_rst");
    check_eq("divu_after_rst_const", {Hi, Lo}, {32'd2, 32'd14});

    // Random back-to-back traffic; each new Start lands in the previous Done cycle
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      run_op(rop, ra, rb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
